cpu_to_wb_adapter: RTL and testbench

Bridge from a simple CPU memory port (single-cycle read/write request strobes) to a Wishbone classic single-transfer master. It sits between the CPU core's memory port and the Wishbone interconnect. Each accepted CPU request becomes exactly one Wishbone cycle, and read data is returned on a registered CPU read-data bus. One transaction is outstanding at a time.

---
 rtl/cpu_wb_pkg.sv | 13 +
 rtl/cpu_if.sv | 17 +
 rtl/wb_if.sv | 20 ++
 rtl/cpu_to_wb_adapter.sv | 107 ++++++++++
 tb/tb_cpu_to_wb_adapter.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_wb_pkg.sv
// Shared types and default widths for the CPU-to-Wishbone bridge.
package cpu_wb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // IDLE: no bus cycle in flight. ACTIVE: waiting for the slave's ack.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/cpu_if.sv
// CPU memory-port signal bundle used by the bench to drive and observe the bridge.
interface cpu_if #(
  parameter int ADDR_W = cpu_wb_pkg::DEF_ADDR_W,
  parameter int DATA_W = cpu_wb_pkg::DEF_DATA_W
) (
  input logic clk
);
  logic              resetn;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] wr_data;
  logic              we;
  logic              rd;
  logic [DATA_W-1:0] rd_data;

  modport driver  (input clk, output resetn, adr, wr_data, we, rd, input rd_data);
  modport monitor (input clk, resetn, adr, wr_data, we, rd, rd_data);
endinterface

// File: rtl/wb_if.sv
// Wishbone classic signal bundle used by the bench to act as the slave and observe the bus.
interface wb_if #(
  parameter int ADDR_W = cpu_wb_pkg::DEF_ADDR_W,
  parameter int DATA_W = cpu_wb_pkg::DEF_DATA_W,
  parameter int SEL_W  = DATA_W / 8
) (
  input logic clk
);
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] dat_o;
  logic [DATA_W-1:0] dat_i;
  logic              we;
  logic              stb;
  logic [SEL_W-1:0]  sel;
  logic              cyc;
  logic              ack;

  modport driver  (input clk, adr, dat_o, we, stb, sel, cyc, output dat_i, ack);
  modport monitor (input clk, adr, dat_o, dat_i, we, stb, sel, cyc, ack);
endinterface

// File: rtl/cpu_to_wb_adapter.sv
// Bridges single-cycle CPU read/write strobes onto one Wishbone classic cycle each.
// One transaction in flight; requests arriving while a cycle is active are dropped.
module cpu_to_wb_adapter
  import cpu_wb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              resetn,     // active-high synchronous reset despite the name
  input  logic [ADDR_W-1:0] memAdr,
  input  logic [DATA_W-1:0] memwrData,
  input  logic              memWe,
  input  logic              memRd,
  output logic [DATA_W-1:0] memrdData,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic              we_o,
  output logic              stb_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic              cyc_o,
  input  logic              ack_i
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] adr_reg, adr_next;
  logic [DATA_W-1:0] dat_reg, dat_next;
  logic [DATA_W-1:0] rd_data_reg, rd_data_next;
  logic              we_reg, we_next;
  logic              stb_reg, stb_next;
  logic              cyc_reg, cyc_next;
  logic [SEL_W-1:0]  sel_reg, sel_next;

  // Next-state and next-output logic; every register holds unless a transition changes it.
  always_comb begin
    state_next   = state_reg;
    adr_next     = adr_reg;
    dat_next     = dat_reg;
    rd_data_next = rd_data_reg;
    we_next      = we_reg;
    stb_next     = stb_reg;
    cyc_next     = cyc_reg;
    sel_next     = sel_reg;
    case (state_reg)
      IDLE: begin
        // A simultaneous write and read is issued as a write.
        if (memWe || memRd) begin
          adr_next   = memAdr;
          dat_next   = memwrData;
          we_next    = memWe;
          cyc_next   = 1'b1;
          stb_next   = 1'b1;
          sel_next   = '1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        // Address/data/controls stay put until the slave acks; new requests are ignored.
        if (ack_i) begin
          if (!we_reg) begin
            rd_data_next = wb_dat_i;
          end
          we_next    = 1'b0;
          cyc_next   = 1'b0;
          stb_next   = 1'b0;
          sel_next   = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset wins over a coincident ack so nothing is captured.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_reg   <= IDLE;
      adr_reg     <= '0;
      dat_reg     <= '0;
      rd_data_reg <= '0;
      we_reg      <= 1'b0;
      stb_reg     <= 1'b0;
      cyc_reg     <= 1'b0;
      sel_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      adr_reg     <= adr_next;
      dat_reg     <= dat_next;
      rd_data_reg <= rd_data_next;
      we_reg      <= we_next;
      stb_reg     <= stb_next;
      cyc_reg     <= cyc_next;
      sel_reg     <= sel_next;
    end
  end

  assign memrdData = rd_data_reg;
  assign wb_adr_o  = adr_reg;
  assign wb_dat_o  = dat_reg;
  assign we_o      = we_reg;
  assign stb_o     = stb_reg;
  assign cyc_o     = cyc_reg;
  assign sel_o     = sel_reg;

endmodule

// File: tb/tb_cpu_to_wb_adapter.sv
// Directed self-checking bench for cpu_to_wb_adapter.
module tb_cpu_to_wb_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  cpu_if c (.clk(clk));
  wb_if  w (.clk(clk));

  cpu_to_wb_adapter dut (
    .clk       (clk),
    .resetn    (c.resetn),
    .memAdr    (c.adr),
    .memwrData (c.wr_data),
    .memWe     (c.we),
    .memRd     (c.rd),
    .memrdData (c.rd_data),
    .wb_adr_o  (w.adr),
    .wb_dat_o  (w.dat_o),
    .wb_dat_i  (w.dat_i),
    .we_o      (w.we),
    .stb_o     (w.stb),
    .sel_o     (w.sel),
    .cyc_o     (w.cyc),
    .ack_i     (w.ack)
  );

  int total = 0;
  int bad   = 0;

  // Counts Wishbone cycles by rising edges of cyc_o.
  int   txn_count = 0;
  logic cyc_q     = 1'b0;
  always @(posedge clk) begin
    cyc_q <= w.cyc;
    if (w.cyc === 1'b1 && cyc_q !== 1'b1) txn_count <= txn_count + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    c.resetn = 1'b1; c.adr = '0; c.wr_data = '0; c.we = 0; c.rd = 0;
    w.dat_i = 32'hFFFF_FFFF; w.ack = 0;
    step(); step();
    chk("rst_cyc",   {31'd0, w.cyc}, 32'd0);
    chk("rst_stb",   {31'd0, w.stb}, 32'd0);
    chk("rst_we",    {31'd0, w.we}, 32'd0);
    chk("rst_sel",   {28'd0, w.sel}, 32'd0);
    chk("rst_adr",   w.adr, 32'd0);
    chk("rst_dat",   w.dat_o, 32'd0);
    chk("rst_rdata", c.rd_data, 32'd0);
    c.resetn = 1'b0;
    step(); step(); step();
    chk("idle_cyc", {31'd0, w.cyc}, 32'd0);
    $display("reset: cyc=%b rdata=%h", w.cyc, c.rd_data);
  endtask

  task automatic test_write();
    c.we = 1; c.adr = 32'h10; c.wr_data = 32'hDEAD_BEEF;
    step();
    c.we = 0; c.adr = 32'hFFFF; c.wr_data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk("wr_cyc", {31'd0, w.cyc}, 32'd1);
      chk("wr_stb", {31'd0, w.stb}, 32'd1);
      chk("wr_we",  {31'd0, w.we}, 32'd1);
      chk("wr_sel", {28'd0, w.sel}, 32'hF);
      chk("wr_adr", w.adr, 32'h10);
      chk("wr_dat", w.dat_o, 32'hDEAD_BEEF);
      if (i == 2) w.ack = 1;
      step();
    end
    w.ack = 0;
    chk("wr_end_cyc", {31'd0, w.cyc}, 32'd0);
    chk("wr_end_we",  {31'd0, w.we}, 32'd0);
    chk("wr_end_sel", {28'd0, w.sel}, 32'd0);
    chk("wr_end_adr", w.adr, 32'h10);
    chk("wr_rdata",   c.rd_data, 32'd0);
    $display("write: adr=%h dat=%h rdata=%h", w.adr, w.dat_o, c.rd_data);
  endtask

  task automatic test_read();
    int t0;
    t0 = txn_count;
    c.rd = 1; c.adr = 32'h20;
    step();
    c.rd = 0;
    chk("rd_cyc", {31'd0, w.cyc}, 32'd1);
    chk("rd_we",  {31'd0, w.we}, 32'd0);
    chk("rd_adr", w.adr, 32'h20);
    w.ack = 1; w.dat_i = 32'h1234_5678;
    step();
    w.ack = 0; w.dat_i = 32'hAAAA_AAAA;
    chk("rd_end_cyc", {31'd0, w.cyc}, 32'd0);
    chk("rd_rdata",   c.rd_data, 32'h1234_5678);
    // A stray ack while idle must not start or capture anything.
    w.ack = 1;
    step();
    w.ack = 0;
    step();
    chk("rd_hold",      c.rd_data, 32'h1234_5678);
    chk("rd_idle_cyc",  {31'd0, w.cyc}, 32'd0);
    chk("rd_txn_count", txn_count - t0, 32'd1);
    $display("read: adr=%h rdata=%h", w.adr, c.rd_data);
  endtask

  task automatic test_collision_drop();
    int t0;
    t0 = txn_count;
    c.we = 1; c.rd = 1; c.adr = 32'h30; c.wr_data = 32'h55;
    step();
    c.we = 0; c.rd = 0;
    chk("col_we",  {31'd0, w.we}, 32'd1);
    chk("col_cyc", {31'd0, w.cyc}, 32'd1);
    c.rd = 1; c.adr = 32'h40;
    step();
    c.rd = 0;
    chk("col_adr_held", w.adr, 32'h30);
    chk("col_we_held",  {31'd0, w.we}, 32'd1);
    w.ack = 1; c.we = 1; c.adr = 32'h44;
    step();
    w.ack = 0; c.we = 0;
    chk("col_end_cyc", {31'd0, w.cyc}, 32'd0);
    step();
    chk("col_drop_cyc", {31'd0, w.cyc}, 32'd0);
    chk("col_txn",      txn_count - t0, 32'd1);
    chk("col_rdata",    c.rd_data, 32'h1234_5678);
    $display("collision: adr=%h dat=%h txns=%0d", w.adr, w.dat_o, txn_count - t0);
  endtask

  task automatic test_reset_mid();
    c.rd = 1; c.adr = 32'h50;
    step();
    c.rd = 0;
    chk("mid_cyc", {31'd0, w.cyc}, 32'd1);
    w.ack = 1; w.dat_i = 32'hCAFE_F00D; c.resetn = 1;
    step();
    w.ack = 0; c.resetn = 0;
    chk("mid_cyc0",  {31'd0, w.cyc}, 32'd0);
    chk("mid_stb0",  {31'd0, w.stb}, 32'd0);
    chk("mid_rdata", c.rd_data, 32'd0);
    chk("mid_adr",   w.adr, 32'd0);
    $display("reset_mid: cyc=%b rdata=%h", w.cyc, c.rd_data);
  endtask

  task automatic test_back_to_back();
    c.we = 1; c.adr = 32'h60; c.wr_data = 32'h11;
    step();
    c.we = 0;
    chk("b2b_wr_cyc", {31'd0, w.cyc}, 32'd1);
    w.ack = 1;
    step();
    w.ack = 0;
    chk("b2b_gap_cyc", {31'd0, w.cyc}, 32'd0);
    c.rd = 1; c.adr = 32'h70;
    step();
    c.rd = 0;
    chk("b2b_rd_cyc", {31'd0, w.cyc}, 32'd1);
    chk("b2b_rd_we",  {31'd0, w.we}, 32'd0);
    chk("b2b_rd_adr", w.adr, 32'h70);
    w.ack = 1; w.dat_i = 32'h9ABC_DEF0;
    step();
    w.ack = 0;
    chk("b2b_rdata", c.rd_data, 32'h9ABC_DEF0);
    chk("b2b_cyc0",  {31'd0, w.cyc}, 32'd0);
    $display("back_to_back: adr=%h rdata=%h", w.adr, c.rd_data);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_collision_drop();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
